// File: rtl/fetch_unit.sv
// PC generator and IF/ID register in front of instruction memory; redirects flush, stalls freeze.
// Latency: one edge from pc to ifid_instr. Backpressure: stall holds pc and IF/ID, redirect overrides it.
// The all-zero word is an ordinary instruction.
module fetch_unit #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 32,
  parameter int LAST_PC = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_offset,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] LAST_PC_V = PC_W'(LAST_PC);
  localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);

  state_t          state;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;

  assign redirect    = jump | branch_taken;
  // Two's-complement add wraps mod 2^PC_W, so negative offsets need no sign handling.
  assign redirect_pc = jump ? jump_target : (ifid_pc + branch_offset);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= '0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (redirect) begin
      pc         <= redirect_pc;
      ifid_valid <= 1'b0;
      state      <= RUN;
      halted     <= 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          ifid_instr <= instruction_in;
          ifid_pc    <= pc;
          ifid_valid <= 1'b1;
          if (pc == LAST_PC_V) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        HALT: begin
          // Present the final word once, then go idle.
          ifid_valid <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a reference model feeding an expected-result queue.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [4:0]  branch_offset;
  logic        jump;
  logic [4:0]  jump_target;
  logic [31:0] instruction_in;
  logic [4:0]  pc;
  logic [31:0] ifid_instr;
  logic [4:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  pc;
    logic [31:0] instr;
    logic [4:0]  ipc;
    logic        v;
    logic        h;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [4:0]  m_pc;
  logic [31:0] m_instr;
  logic [4:0]  m_ipc;
  logic        m_v;
  logic        m_h;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [4:0] a);
    logic [31:0] w;
    w = (a == 5'd0) ? 32'h0 : (32'hC0DE_0000 + {27'd0, a} * 32'h0101);
    return w;
  endfunction

  assign instruction_in = instr_of(pc);

  fetch_unit #(.PC_W(5), .INSTR_W(32), .LAST_PC(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .instruction_in (instruction_in),
    .pc             (pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_ipc = '0; m_v = 1'b0; m_h = 1'b0;
    q.delete();
  endtask

  // Drive one edge's inputs, predict the result, then compare after the edge.
  task automatic step(input logic s, input logic bt, input logic [4:0] off,
                      input logic j, input logic [4:0] jt);
    exp_t e;
    stall = s; branch_taken = bt; branch_offset = off; jump = j; jump_target = jt;
    if (j || bt) begin
      m_pc = j ? jt : (m_ipc + off);
      m_v  = 1'b0;
      m_h  = 1'b0;
    end else if (!s) begin
      if (!m_h) begin
        m_instr = instr_of(m_pc);
        m_ipc   = m_pc;
        m_v     = 1'b1;
        if (m_pc == 5'd10) m_h = 1'b1;
        else m_pc = m_pc + 5'd1;
      end else begin
        m_v = 1'b0;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.v = m_v; e.h = m_h;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_pc", {27'd0, pc}, {27'd0, e.pc});
    chk("sb_ifid_instr", ifid_instr, e.instr);
    chk("sb_ifid_pc", {27'd0, ifid_pc}, {27'd0, e.ipc});
    chk("sb_ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
    chk("sb_halted", {31'd0, halted}, {31'd0, e.h});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_target = '0;
    model_reset();
    #12;
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'd0);
    chk("rst_ifid_pc", {27'd0, ifid_pc}, 32'd0);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Free run: first edge presents the all-zero word at PC 0 as valid.
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("first_ifid_pc", {27'd0, ifid_pc}, 32'd0);
    chk("first_valid", {31'd0, ifid_valid}, 32'd1);
    chk("first_zero_instr", ifid_instr, 32'd0);
    run(10);
    chk("halt_ifid_pc", {27'd0, ifid_pc}, 32'd10);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_valid_once", {31'd0, ifid_valid}, 32'd1);
    run(1);
    chk("halt_pc_hold", {27'd0, pc}, 32'd10);
    chk("halt_valid_drop", {31'd0, ifid_valid}, 32'd0);
    run(2);

    // Jump out of HALT back to 0.
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd0);
    chk("unhalt", {31'd0, halted}, 32'd0);
    chk("unhalt_pc", {27'd0, pc}, 32'd0);
    run(4);
    chk("pre_stall_pc", {27'd0, pc}, 32'd4);

    // Stall three edges at pc=4.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("stall_pc", {27'd0, pc}, 32'd4);
    chk("stall_ifid_pc", {27'd0, ifid_pc}, 32'd3);
    chk("stall_valid", {31'd0, ifid_valid}, 32'd1);
    run(1);
    chk("unstall_ifid_pc", {27'd0, ifid_pc}, 32'd4);
    chk("unstall_pc", {27'd0, pc}, 32'd5);

    // Backward branch of -3 from ifid_pc=6.
    run(2);
    chk("pre_branch_ifid_pc", {27'd0, ifid_pc}, 32'd6);
    step(1'b0, 1'b1, 5'b11101, 1'b0, 5'd0);
    chk("branch_pc", {27'd0, pc}, 32'd3);
    chk("branch_flush", {31'd0, ifid_valid}, 32'd0);
    run(1);
    chk("branch_ifid_pc", {27'd0, ifid_pc}, 32'd3);

    // Jump + branch + stall together: jump wins, stall ignored.
    step(1'b1, 1'b1, 5'd7, 1'b1, 5'd2);
    chk("jump_prio_pc", {27'd0, pc}, 32'd2);
    chk("jump_prio_flush", {31'd0, ifid_valid}, 32'd0);

    // Jump beyond LAST_PC: wrap 31 -> 0 and halt at 10.
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd31);
    chk("j31_pc", {27'd0, pc}, 32'd31);
    run(1);
    chk("wrap_pc", {27'd0, pc}, 32'd0);
    chk("wrap_ifid_pc", {27'd0, ifid_pc}, 32'd31);
    for (int i = 0; i < 20 && !m_h; i++) run(1);
    chk("wrap_halted", {31'd0, halted}, 32'd1);
    chk("wrap_halt_ifid_pc", {27'd0, ifid_pc}, 32'd10);

    // Async reset mid-run at pc=7, with a stall and redirect pending.
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
    run(2);
    chk("pre_rst_pc", {27'd0, pc}, 32'd7);
    stall = 1'b1; jump = 1'b1; jump_target = 5'd20;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", {27'd0, pc}, 32'd0);
    chk("arst_ifid_instr", ifid_instr, 32'd0);
    chk("arst_ifid_pc", {27'd0, ifid_pc}, 32'd0);
    chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(3);
    chk("post_rst_pc", {27'd0, pc}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
